// File: rtl/mux_arbiter_4.sv
// mux_arbiter_4 -- four-way round-robin arbiter that captures the winning
// requester's data word into a registered output slot.
//
// Ports
//   clk        : rising-edge clock for all state
//   rst_n      : asynchronous active-low reset
//   req[3:0]   : request bits, bit i = requester i (0=a, 1=b, 2=c, 3=d)
//   a, b, c, d : requester data words (W bits), sampled only at capture
//   lock[3:0]  : (MUX_ARB_LOCK_EN only) lock[k] sampled at capture keeps k's priority
//   out_ready  : downstream accepts out_data when out_valid && out_ready
//   gnt[3:0]   : one-cycle one-hot pulse for the requester just captured
//   c1, c0     : registered select of the current/last grant ({c1,c0} = index)
//   out_data   : captured data word
//   out_valid  : out_data holds an untransferred word
//   xfer_cnt   : completed transfers, wraps 255 -> 0
//   dbg_busy_o : FSM state (1 = BUSY) for checkers
//
// Optional feature: define MUX_ARB_LOCK_EN to add the lock port and the
// 4-grant locked-burst cap.
//
// Handshake: a word moves downstream on a rising edge where out_valid and
// out_ready are both high; out_data/out_valid/{c1,c0} are frozen until then,
// and out_ready has no effect while out_valid is low.
module mux_arbiter_4 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
`ifdef MUX_ARB_LOCK_EN
  input  logic [3:0]   lock,
`endif
  input  logic         out_ready,
  output logic [3:0]   gnt,
  output logic         c1,
  output logic         c0,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic [7:0]   xfer_cnt,
  output logic         dbg_busy_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e       state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [1:0]   sel_q, sel_d;
  logic [3:0]   gnt_q, gnt_d;
  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic [7:0]   cnt_q, cnt_d;
`ifdef MUX_ARB_LOCK_EN
  logic         locked_q, locked_d;
  logic [1:0]   burst_q, burst_d;
`endif

  logic [W-1:0] data_arr [4];
  logic         found;
  logic [1:0]   pick;
  logic [1:0]   idx;

  assign data_arr[0] = a;
  assign data_arr[1] = b;
  assign data_arr[2] = c;
  assign data_arr[3] = d;

  // Search order ptr+1, ptr+2, ptr+3, ptr: the last winner has lowest priority.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = ptr_q;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = 4'b0000;
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
`ifdef MUX_ARB_LOCK_EN
    locked_d = locked_q;
    burst_d  = burst_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = pick;
          data_d  = data_arr[pick];
          gnt_d   = 4'b0001 << pick;
          valid_d = 1'b1;
          state_d = BUSY;
`ifdef MUX_ARB_LOCK_EN
          locked_d = lock[pick];
`endif
        end
      end
      BUSY: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + 8'd1;
          state_d = IDLE;
`ifdef MUX_ARB_LOCK_EN
          // A locked grant keeps ptr so k wins again, but the 4th consecutive
          // locked grant releases priority and restarts the burst count.
          if (locked_q && burst_q != 2'd3) begin
            burst_d = burst_q + 2'd1;
          end else begin
            ptr_d   = sel_q;
            burst_d = 2'd0;
          end
`else
          ptr_d = sel_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= 8'd0;
`ifdef MUX_ARB_LOCK_EN
      locked_q <= 1'b0;
      burst_q  <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
`ifdef MUX_ARB_LOCK_EN
      locked_q <= locked_d;
      burst_q  <= burst_d;
`endif
    end
  end

  assign gnt        = gnt_q;
  assign c1         = sel_q[1];
  assign c0         = sel_q[0];
  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign xfer_cnt   = cnt_q;
  assign dbg_busy_o = (state_q == BUSY);

endmodule
